// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Instruction fetch front-end. Owns the program counter, drives it onto the
// combinational instruction ROM, and captures each returned word together with
// its PC into a small prefetch FIFO. The FIFO head goes to decode over a
// valid/ready handshake. Execute can redirect fetch; a redirect flushes
// everything in flight.
//
// Parameters
//   RESET_PC    PC loaded on reset
//   FIFO_DEPTH  prefetch entries; must be a power of 2 and >= 2
//
// Ports
//   clk             in   1   clock, all state on posedge
//   rst             in   1   synchronous active-high reset
//   rom_addr        out  32  fetch address (the PC register)
//   rom_instr       in   32  ROM word for rom_addr, same cycle
//   redirect_valid  in   1   flush and load redirect_pc
//   redirect_pc     in   32  redirect target (bits [1:0] ignored)
//   inst_valid      out  1   FIFO head valid
//   inst_ready      in   1   decode accepts head
//   inst_data       out  32  head instruction, NOP (32'h00000013) when empty
//   inst_pc         out  32  PC of head instruction, 0 when empty
//
// Optional feature (macro FETCH_PERF_CNT_EN):
//   perf_fetch_cnt  out  32  pushes into the FIFO, wraps at 2^32
//   perf_stall_cnt  out  32  cycles with FIFO full and no pop, wraps at 2^32
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  // Prefetch storage: instruction word and its PC per entry.
  logic [31:0] mem_instr [FIFO_DEPTH];
  logic [31:0] mem_pc    [FIFO_DEPTH];

  logic [31:0]      pc_reg,     pc_next;
  logic [CNT_W-1:0] count_reg,  count_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;

  logic full;
  logic pop;
  logic push;

  // Head is a plain mux of registered state, so inst_ready never reaches
  // rom_addr combinationally.
  assign full       = (count_reg == DEPTH_C);
  assign inst_valid = (count_reg != '0);
  assign inst_data  = inst_valid ? mem_instr[rd_ptr_reg] : NOP;
  assign inst_pc    = inst_valid ? mem_pc[rd_ptr_reg]    : 32'h0;
  assign rom_addr   = pc_reg;

  assign pop  = inst_valid & inst_ready;
  // A full FIFO may still accept a word when the head leaves in the same
  // cycle; the slot being written is the one being popped.
  assign push = ~redirect_valid & (~full | pop);

  always_comb begin
    pc_next     = pc_reg;
    count_next  = count_reg;
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;

    if (redirect_valid) begin
      // Redirect wins over all bookkeeping: a simultaneous pop is still a
      // completed transfer for decode, but the FIFO is emptied regardless.
      pc_next     = {redirect_pc[31:2], 2'b00};
      count_next  = '0;
      rd_ptr_next = '0;
      wr_ptr_next = '0;
    end else begin
      if (push) begin
        pc_next     = pc_reg + 32'd4;
        wr_ptr_next = wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + 1'b1;
      end
      if (push && !pop) begin
        count_next = count_reg + 1'b1;
      end else if (pop && !push) begin
        count_next = count_reg - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg     <= RESET_PC;
      count_reg  <= '0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
    end else begin
      pc_reg     <= pc_next;
      count_reg  <= count_next;
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
    end
  end

  // Storage needs no reset: entries are only visible while count covers them.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_instr[wr_ptr_reg] <= rom_instr;
      mem_pc[wr_ptr_reg]    <= pc_reg;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_reg;
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_reg <= '0;
      stall_cnt_reg <= '0;
    end else begin
      if (push) begin
        fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
      end
      if (full && !pop) begin
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt = fetch_cnt_reg;
  assign perf_stall_cnt = stall_cnt_reg;
`endif

endmodule
